pulse_timer: RTL and testbench
==============================

# pulse_timer

Programmable periodic/one-shot pulse generator feeding single-cycle `pulse_out` strobes to LED sequencers and other tick-driven blocks. Counts enabled `clk` cycles against a runtime-loadable limit and emits a one-cycle strobe at each period boundary. Limit reloads are shadowed so the running period is never torn. With `en`, `start` and `oneshot` tied (1, 0, 0) and `load` tied 0, it behaves as a free-running divider of period `DEFAULT_LIMIT`.

## Interface
- `WIDTH`, 32, width of counter and limit.
- `DEFAULT_LIMIT`, 25, active and shadow limit after reset; must fit in `WIDTH` bits.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  count enable; low freezes counter, no pulses.
- `limit`  in  WIDTH  new period in cycles; sampled only when `load`=1.
- `load`  in  1  one-cycle strobe: capture `limit` into shadow register.
- `oneshot`  in  1  0 = continuous, 1 = stop after next pulse; sampled at the terminal edge.
- `start`  in  1  one-cycle strobe: (re)start a period from count 0.
- `pulse_out`  out  1  registered one-cycle strobe at period end.
- `busy`  out  1  high in RUN state.
- `count`  out  WIDTH  current count; present only with `PULSE_TIMER_COUNT_EN`.

## Operation
- Registers: `cnt_q`, `lim_q` (active), `lim_sh` (shadow), `state` ∈ {IDLE, RUN}.
- Reset: `cnt_q`=0, `lim_q`=`lim_sh`=`DEFAULT_LIMIT`, state RUN, `pulse_out`=0, `busy`=1, `count`=0.
- Effective limit L = `lim_q`, except `lim_q`=0 is treated as L=1.
- Terminal event T: state RUN, `en`=1 and `cnt_q`==L-1.
- RUN, `en`=1, not T: `cnt_q` += 1.
- On T: `cnt_q`<=0; `pulse_out`<=1 for one cycle; `lim_q`<=`lim_sh`. If `oneshot`=1, go to IDLE; otherwise stay in RUN.
- RUN, `en`=0: `cnt_q` and state hold; `pulse_out`<=0.
- IDLE: `cnt_q` held at 0, no pulses; `start` -> RUN with `lim_q`<=`lim_sh`.
- `start` in RUN (retrigger): `cnt_q`<=0, `lim_q`<=`lim_sh`, no pulse. `start` has priority over T in the same cycle: no pulse is emitted.
- `load`: `lim_sh`<=`limit`. If `load` coincides with T or `start`, the loaded value is the one transferred to `lim_q`, so it takes effect for the immediately following period.
- `load` at any other time does not change the running period.
- `cnt_q` never exceeds L-1. Arithmetic is unsigned `WIDTH`-bit with no wrap-around in normal operation.
- Reset mid-period aborts the period: no pulse, all registers return to reset values.

## Timing
- Period L cycles with `en` continuously high: `pulse_out` is high on every L-th edge after reset release or `start`.
- After reset deasserts with L=25, first `pulse_out` is high in the cycle after the 25th enabled edge. The counter is 24 at that edge.
- `pulse_out` latency from T: 1 cycle (registered). It is never high for two consecutive cycles unless L=1.
- L=1: `pulse_out` is high every enabled cycle.
- `busy` updates on the edge at which state changes. In one-shot mode, `busy` falls on the same edge at which `pulse_out` rises.
- Each cycle with `en`=0 stretches the period by exactly one cycle.

## Configuration
- Macro `PULSE_TIMER_COUNT_EN`.
- Defined: output port `count` exists and mirrors `cnt_q` (same-cycle register value).
- Undefined: port `count` is absent. All other behaviour is identical, and timing is unaffected.

## Test plan
- Reset release, defaults, `en`=1: pulses every 25 cycles, first in cycle 25. `busy`=1. `count` runs 0..24, then wraps to 0.
- `load` with `limit`=4 at count 10, L=25: current period still ends at 25. Following periods are 4 cycles each.
- `oneshot`=1 with L=5: exactly one pulse, then `busy`=0 and no further pulses. `start` after 3 idle cycles: next pulse 5 cycles later.
- `en` low for 3 cycles mid-period with L=8: that period measures 11 cycles, with no pulse during the stall.
- `start` asserted in the same cycle as T: no pulse, count restarts at 0. `load limit=0` plus `start`: pulse every cycle thereafter.
- `rst` asserted at count 20: no pulse, and all outputs return to reset values on the next edge. Resumes with period 25.

Source files
------------

// File: rtl/pulse_timer.sv
// Programmable periodic/one-shot pulse generator with shadowed limit reloads.
// Define PULSE_TIMER_COUNT_EN to expose the running counter on port `count`.
module pulse_timer #(
  parameter int          WIDTH         = 32,
  parameter int unsigned DEFAULT_LIMIT = 32'd25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic             oneshot,
  input  logic             start,
  output logic             pulse_out,
  output logic             busy
`ifdef PULSE_TIMER_COUNT_EN
  ,
  output logic [WIDTH-1:0] count
`endif
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] LIM_RESET = WIDTH'(DEFAULT_LIMIT);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] lim_r, lim_s;
  logic [WIDTH-1:0] lim_sh_r, lim_sh_s;
  logic [WIDTH-1:0] lim_eff_s;
  logic             term_s;
  logic             pulse_r, pulse_s;

  // Effective period and terminal-count detection; a zero limit behaves as a period of one
  always_comb begin
    if (lim_r == ZERO) begin
      lim_eff_s = ONE;
    end else begin
      lim_eff_s = lim_r;
    end
    term_s = (state_r == RUN) && en && (cnt_r == (lim_eff_s - ONE));
  end

  // Next-state, counter, limit and strobe logic
  always_comb begin
    cnt_s   = cnt_r;
    lim_s   = lim_r;
    state_s = state_r;
    pulse_s = 1'b0;
    // A load coinciding with a reload point is forwarded straight into the active limit
    if (load) begin
      lim_sh_s = limit;
    end else begin
      lim_sh_s = lim_sh_r;
    end
    case (state_r)
      RUN: begin
        if (start) begin
          cnt_s = ZERO;
          lim_s = lim_sh_s;
        end else if (term_s) begin
          cnt_s   = ZERO;
          lim_s   = lim_sh_s;
          pulse_s = 1'b1;
          if (oneshot) begin
            state_s = IDLE;
          end else begin
            state_s = RUN;
          end
        end else if (en) begin
          cnt_s = cnt_r + ONE;
        end else begin
          cnt_s = cnt_r;
        end
      end
      IDLE: begin
        cnt_s = ZERO;
        if (start) begin
          state_s = RUN;
          lim_s   = lim_sh_s;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        cnt_s   = ZERO;
        state_s = RUN;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= RUN;
      cnt_r    <= ZERO;
      lim_r    <= LIM_RESET;
      lim_sh_r <= LIM_RESET;
      pulse_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      lim_r    <= lim_s;
      lim_sh_r <= lim_sh_s;
      pulse_r  <= pulse_s;
    end
  end

  assign pulse_out = pulse_r;
  assign busy      = (state_r == RUN);
`ifdef PULSE_TIMER_COUNT_EN
  assign count     = cnt_r;
`endif

endmodule

// File: tb/tb_pulse_timer.sv
// Self-checking bench for pulse_timer: directed scenarios plus randomized traffic
// against a "cycles remaining in period" reference model.
module tb_pulse_timer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, en, load, oneshot, start;
  logic [W-1:0] limit;
  logic         pulse_out, busy;
`ifdef PULSE_TIMER_COUNT_EN
  logic [W-1:0] count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: running flag, current period, enabled edges left until the strobe
  bit          m_run, m_pulse;
  longint      m_per, m_left;
  logic [31:0] m_sh;

  always #5 clk = ~clk;

  pulse_timer #(.WIDTH(W), .DEFAULT_LIMIT(32'd25)) dut (
    .clk(clk), .rst(rst), .en(en), .limit(limit), .load(load),
    .oneshot(oneshot), .start(start), .pulse_out(pulse_out), .busy(busy)
`ifdef PULSE_TIMER_COUNT_EN
    , .count(count)
`endif
  );

  function automatic longint eff(logic [31:0] v);
    return (v == 32'd0) ? 64'd1 : longint'(v);
  endfunction

  task automatic tick();
    logic [31:0] shn;
    @(posedge clk);
    if (rst) begin
      m_run = 1'b1; m_per = 25; m_left = 25; m_sh = 32'd25; m_pulse = 1'b0;
    end else begin
      shn = load ? limit : m_sh;
      m_pulse = 1'b0;
      if (m_run) begin
        if (start) begin
          m_per = eff(shn); m_left = m_per;
        end else if (en) begin
          m_left--;
          if (m_left == 0) begin
            m_pulse = 1'b1; m_per = eff(shn); m_left = m_per;
            if (oneshot) m_run = 1'b0;
          end
        end
      end else if (start) begin
        m_run = 1'b1; m_per = eff(shn); m_left = m_per;
      end
      m_sh = shn;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; load = 1'b0; start = 1'b0; oneshot = 1'b0; limit = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int first = -1;
    do_reset();
    checks++;
    if (pulse_out !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL reset_out pulse=%b busy=%b want 0 1", pulse_out, busy);
    end
`ifdef PULSE_TIMER_COUNT_EN
    checks++;
    if (count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
`endif
    for (int i = 1; i <= 30; i++) begin
      tick();
      checks++;
      if (pulse_out !== m_pulse || busy !== m_run) begin
        errors++; $display("FAIL reset_run i=%0d pulse=%b/%b busy=%b/%b", i, pulse_out, m_pulse, busy, m_run);
      end
      if (pulse_out === 1'b1 && first < 0) first = i;
    end
    checks++;
    if (first !== 25) begin errors++; $display("FAIL reset_first_pulse got %0d want 25", first); end
  endtask

  task automatic test_load();
    int p[$];
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      load  = (i == 11);
      limit = 32'd4;
      tick();
      checks++;
      if (pulse_out !== m_pulse || busy !== m_run) begin
        errors++; $display("FAIL load_run i=%0d pulse=%b/%b", i, pulse_out, m_pulse);
      end
`ifdef PULSE_TIMER_COUNT_EN
      checks++;
      if (count !== 32'(m_per - m_left)) begin
        errors++; $display("FAIL load_count i=%0d got %0d want %0d", i, count, m_per - m_left);
      end
`endif
      if (pulse_out === 1'b1) p.push_back(i);
    end
    load = 1'b0;
    checks++;
    if (p.size() < 3 || p[0] != 25 || p[1] != 29 || p[2] != 33) begin
      errors++; $display("FAIL load_periods got %0d pulses first=%0d want 25,29,33", p.size(), (p.size() > 0) ? p[0] : -1);
    end
  endtask

  task automatic test_oneshot();
    int n = 0;
    int first = -1;
    do_reset();
    load = 1'b1; limit = 32'd5; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0; oneshot = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++;
      if (pulse_out !== m_pulse || busy !== m_run) begin
        errors++; $display("FAIL oneshot_run i=%0d pulse=%b/%b busy=%b/%b", i, pulse_out, m_pulse, busy, m_run);
      end
      if (pulse_out === 1'b1) n++;
    end
    checks++;
    if (n !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL oneshot_single pulses=%0d busy=%b want 1 0", n, busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (pulse_out !== m_pulse || busy !== m_run) begin
        errors++; $display("FAIL oneshot_restart i=%0d pulse=%b/%b", i, pulse_out, m_pulse);
      end
      if (pulse_out === 1'b1 && first < 0) first = i;
    end
    checks++;
    if (first !== 5) begin errors++; $display("FAIL oneshot_latency got %0d want 5", first); end
    oneshot = 1'b0;
  endtask

  task automatic test_stall();
    int p1 = -1;
    int p2 = -1;
    do_reset();
    load = 1'b1; limit = 32'd8; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    for (int i = 0; i < 20 && p1 < 0; i++) begin
      tick();
      if (pulse_out === 1'b1) p1 = cyc;
    end
    for (int i = 1; i <= 20; i++) begin
      en = !(i >= 3 && i <= 5);
      tick();
      checks++;
      if (pulse_out !== m_pulse || busy !== m_run) begin
        errors++; $display("FAIL stall_run i=%0d pulse=%b/%b", i, pulse_out, m_pulse);
      end
      if (pulse_out === 1'b1 && p2 < 0) p2 = cyc;
    end
    en = 1'b1;
    checks++;
    if (p1 < 0 || p2 < 0 || (p2 - p1) !== 11) begin
      errors++; $display("FAIL stall_period got %0d want 11", p2 - p1);
    end
  endtask

  task automatic test_start_at_t();
    do_reset();
    load = 1'b1; limit = 32'd4; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    for (int i = 0; i < 10 && !(m_run && m_left == 1); i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (pulse_out !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL start_at_t pulse=%b busy=%b want 0 1", pulse_out, busy);
    end
`ifdef PULSE_TIMER_COUNT_EN
    checks++;
    if (count !== 32'd0) begin errors++; $display("FAIL start_at_t_count got %0d want 0", count); end
`endif
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (pulse_out !== (i == 4)) begin
        errors++; $display("FAIL start_restart i=%0d pulse=%b want %b", i, pulse_out, (i == 4));
      end
    end
    load = 1'b1; limit = 32'd0; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (pulse_out !== 1'b1 || m_pulse !== 1'b1) begin
        errors++; $display("FAIL limit_zero i=%0d pulse=%b model=%b want 1", i, pulse_out, m_pulse);
      end
    end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    do_reset();
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (pulse_out !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL reset_mid pulse=%b busy=%b want 0 1", pulse_out, busy);
    end
`ifdef PULSE_TIMER_COUNT_EN
    checks++;
    if (count !== 32'd0) begin errors++; $display("FAIL reset_mid_count got %0d want 0", count); end
`endif
    for (int i = 1; i <= 26; i++) begin
      tick();
      if (pulse_out === 1'b1 && first < 0) first = i;
    end
    checks++;
    if (first !== 25) begin errors++; $display("FAIL reset_mid_resume got %0d want 25", first); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      start   = ($urandom_range(0, 29) == 0);
      load    = ($urandom_range(0, 9) == 0);
      limit   = $urandom_range(0, 7);
      oneshot = ($urandom_range(0, 5) == 0);
      tick();
      checks++;
      if (pulse_out !== m_pulse || busy !== m_run) begin
        errors++; $display("FAIL random i=%0d pulse=%b/%b busy=%b/%b", i, pulse_out, m_pulse, busy, m_run);
      end
`ifdef PULSE_TIMER_COUNT_EN
      checks++;
      if (count !== 32'(m_run ? (m_per - m_left) : 0)) begin
        errors++; $display("FAIL random_count i=%0d got %0d", i, count);
      end
`endif
    end
    en = 1'b1; start = 1'b0; load = 1'b0; oneshot = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; oneshot = 1'b0; start = 1'b0; limit = '0;
    test_reset();
    test_load();
    test_oneshot();
    test_stall();
    test_start_at_t();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
